fifo_sync: RTL and testbench

Parametrised single-clock FIFO for sample buffering between DSP stages in the FM demodulation chain (e.g. decimator to demodulator, demodulator to audio filters). It supersedes the dual-clock FIFO wherever producer and consumer share a clock. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/fifo_sync.sv | 153 +++++++++++++++
 tb/tb_fifo_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync
// Brief   : Single-clock sample FIFO with occupancy count, almost flags,
//           sticky error flags, synchronous flush and optional FWFT read.
// Rev     : 1.0
// ============================================================================
module fifo_sync #(
    parameter int FIFO_DATA_WIDTH     = 32,
    parameter int FIFO_BUFFER_SIZE    = 1024,
    parameter int FIFO_FWFT           = 0,
    parameter int ALMOST_FULL_THRESH  = FIFO_BUFFER_SIZE - 4,
    parameter int ALMOST_EMPTY_THRESH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0]        din,
    output logic                              full,
    output logic                              almost_full,
    input  logic                              rd_en,
    output logic [FIFO_DATA_WIDTH-1:0]        dout,
    output logic                              empty,
    output logic                              almost_empty,
    output logic [$clog2(FIFO_BUFFER_SIZE):0] level,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int            c_AW      = $clog2(FIFO_BUFFER_SIZE);
    localparam int            c_LW      = c_AW + 1;
    localparam logic [c_LW-1:0] c_DEPTH = c_LW'(FIFO_BUFFER_SIZE);
    localparam logic [c_LW-1:0] c_AF    = c_LW'(ALMOST_FULL_THRESH);
    localparam logic [c_LW-1:0] c_AE    = c_LW'(ALMOST_EMPTY_THRESH);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam bit            c_FWFT    = (FIFO_FWFT != 0);

    logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_BUFFER_SIZE];

    logic [c_AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [c_LW-1:0]            level_q, level_d;
    logic                       full_q, full_d;
    logic                       afull_q, afull_d;
    logic                       empty_q, empty_d;
    logic                       aempty_q, aempty_d;
    logic [FIFO_DATA_WIDTH-1:0] dout_q, dout_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;
    logic                       ovalid_q, ovalid_d;

    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_load;
    logic [c_LW-1:0]            w_mem_cnt;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        ovalid_d  = ovalid_q;

        w_wr_acc  = wr_en && !full_q;
        w_rd_acc  = rd_en && !empty_q;
        // In FWFT mode the output register holds one word that level counts
        w_mem_cnt = level_q - c_LW'(ovalid_q);
        w_load    = c_FWFT ? ((!ovalid_q || w_rd_acc) && (w_mem_cnt != '0))
                           : w_rd_acc;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            dout_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            ovalid_d = 1'b0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_load) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                dout_d   = mem_q[rd_ptr_q];
                ovalid_d = c_FWFT;
            end else if (w_rd_acc) begin
                ovalid_d = 1'b0;
            end
            level_d = level_q + c_LW'(w_wr_acc) - c_LW'(w_rd_acc);
            if (wr_en && full_q) begin
                ovf_d = 1'b1;
            end
            if (rd_en && empty_q) begin
                udf_d = 1'b1;
            end
        end

        full_d   = (level_d == c_DEPTH);
        afull_d  = (level_d >= c_AF);
        aempty_d = (level_d <= c_AE);
        empty_d  = c_FWFT ? !ovalid_d : (level_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Storage is deliberately left out of reset and flush
    always_ff @(posedge clk) begin
        if (!reset && !clear && w_wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign dout         = dout_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_sync
// Brief   : Scoreboard bench for fifo_sync, standard and FWFT instances.
// Rev     : 1.0
// ============================================================================
module tb_fifo_sync;

    localparam int c_DW = 16;
    localparam int c_N  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              s_clear = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [c_DW-1:0]   s_din = '0, s_dout;
    logic              s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
    logic [3:0]        s_level;

    logic              f_clear = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [c_DW-1:0]   f_din = '0, f_dout;
    logic              f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
    logic [3:0]        f_level;

    fifo_sync #(
        .FIFO_DATA_WIDTH(c_DW), .FIFO_BUFFER_SIZE(c_N), .FIFO_FWFT(0),
        .ALMOST_FULL_THRESH(6), .ALMOST_EMPTY_THRESH(1)
    ) u_std (
        .clk(clk), .reset(reset), .clear(s_clear), .wr_en(s_wr_en), .din(s_din),
        .full(s_full), .almost_full(s_afull), .rd_en(s_rd_en), .dout(s_dout),
        .empty(s_empty), .almost_empty(s_aempty), .level(s_level),
        .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_sync #(
        .FIFO_DATA_WIDTH(c_DW), .FIFO_BUFFER_SIZE(c_N), .FIFO_FWFT(1),
        .ALMOST_FULL_THRESH(6), .ALMOST_EMPTY_THRESH(1)
    ) u_fwft (
        .clk(clk), .reset(reset), .clear(f_clear), .wr_en(f_wr_en), .din(f_din),
        .full(f_full), .almost_full(f_afull), .rd_en(f_rd_en), .dout(f_dout),
        .empty(f_empty), .almost_empty(f_aempty), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf)
    );

    int              errors = 0;
    int              checks = 0;
    logic [c_DW-1:0] s_q[$];
    logic [c_DW-1:0] f_q[$];
    int              s_lvl;
    logic [c_DW-1:0] s_dexp;
    logic            s_ovf_m, s_udf_m;
    logic            f_vis, f_ovf_m, f_udf_m;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic init_models();
        s_q.delete(); f_q.delete();
        s_lvl = 0; s_dexp = '0; s_ovf_m = 1'b0; s_udf_m = 1'b0;
        f_vis = 1'b0; f_ovf_m = 1'b0; f_udf_m = 1'b0;
    endtask

    task automatic s_check(input string tag);
        logic [5:0] act, exp;
        act = {s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf};
        exp = {s_lvl == c_N, s_lvl >= 6, s_lvl == 0, s_lvl <= 1, s_ovf_m, s_udf_m};
        chk({tag, ".level"}, 32'(s_level), 32'(s_lvl));
        chk({tag, ".flags"}, 32'(act), 32'(exp));
        chk({tag, ".dout"}, 32'(s_dout), 32'(s_dexp));
    endtask

    task automatic f_check(input string tag);
        logic [5:0] act, exp;
        act = {f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf};
        exp = {f_q.size() == c_N, f_q.size() >= 6, !f_vis, f_q.size() <= 1, f_ovf_m, f_udf_m};
        chk({tag, ".level"}, 32'(f_level), 32'(f_q.size()));
        chk({tag, ".flags"}, 32'(act), 32'(exp));
        if (f_vis) chk({tag, ".head"}, 32'(f_dout), 32'(f_q[0]));
    endtask

    // One clock of the standard-mode instance; called at posedge+1
    task automatic s_cycle(input logic wr, input logic rd, input logic [c_DW-1:0] d,
                           input logic clr, input string tag);
        logic wacc, racc;
        wacc = wr && (s_lvl != c_N);
        racc = rd && (s_lvl != 0);
        s_wr_en = wr; s_rd_en = rd; s_din = d; s_clear = clr;
        @(posedge clk); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_clear = 1'b0;
        if (clr) begin
            s_q.delete(); s_lvl = 0; s_dexp = '0; s_ovf_m = 1'b0; s_udf_m = 1'b0;
        end else begin
            if (wr && !wacc) s_ovf_m = 1'b1;
            if (rd && !racc) s_udf_m = 1'b1;
            if (racc) s_dexp = s_q.pop_front();
            if (wacc) s_q.push_back(d);
            s_lvl = s_lvl + int'(wacc) - int'(racc);
        end
        s_check(tag);
    endtask

    // One clock of the FWFT instance; a pop compares the presented word
    task automatic f_cycle(input logic wr, input logic rd, input logic [c_DW-1:0] d,
                           input string tag);
        logic wacc, racc;
        logic [c_DW-1:0] popped;
        wacc = wr && (f_q.size() != c_N);
        racc = rd && f_vis;
        if (racc) begin
            popped = f_q.pop_front();
            chk({tag, ".pop"}, 32'(f_dout), 32'(popped));
        end
        f_wr_en = wr; f_rd_en = rd; f_din = d;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
        if (wr && !wacc) f_ovf_m = 1'b1;
        if (rd && !racc) f_udf_m = 1'b1;
        f_vis = (f_q.size() != 0);
        if (wacc) f_q.push_back(d);
        f_check(tag);
    endtask

    initial begin
        init_models();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        s_check("reset");
        f_check("f_reset");

        // Asynchronous reset with five words held and a non-zero dout
        for (int i = 1; i <= 6; i++) s_cycle(1'b1, 1'b0, 16'(i), 1'b0, "pre_rst");
        s_cycle(1'b0, 1'b1, '0, 1'b0, "pre_rst_rd");
        #2 reset = 1'b1;
        #1;
        init_models();
        s_check("async_rst");
        @(posedge clk); #1 reset = 1'b0;

        // Fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) s_cycle(1'b1, 1'b0, 16'(i), 1'b0, "fill");
        s_cycle(1'b1, 1'b0, 16'h00AA, 1'b0, "ovf_wr");
        for (int i = 0; i < 8; i++) s_cycle(1'b0, 1'b1, '0, 1'b0, "drain");
        s_cycle(1'b0, 1'b1, '0, 1'b0, "udf_rd");

        // Simultaneous read/write at full, mid and empty
        s_cycle(1'b0, 1'b0, '0, 1'b1, "clr1");
        for (int i = 0; i < 8; i++) s_cycle(1'b1, 1'b0, 16'h0300 + 16'(i), 1'b0, "fill2");
        s_cycle(1'b1, 1'b1, 16'h0099, 1'b0, "rw_full");
        for (int i = 0; i < 4; i++) s_cycle(1'b0, 1'b1, '0, 1'b0, "to3");
        s_cycle(1'b1, 1'b1, 16'h0055, 1'b0, "rw_mid");
        for (int i = 0; i < 3; i++) s_cycle(1'b0, 1'b1, '0, 1'b0, "to0");
        s_cycle(1'b1, 1'b1, 16'h0066, 1'b0, "rw_empty");
        s_cycle(1'b0, 1'b1, '0, 1'b0, "rd_66");

        // Stream 20 words across the pointer wrap
        s_cycle(1'b0, 1'b0, '0, 1'b1, "clr2");
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 5; k++) s_cycle(1'b1, 1'b0, 16'h0100 + 16'(r * 5 + k), 1'b0, "wrap_wr");
            for (int k = 0; k < 5; k++) s_cycle(1'b0, 1'b1, '0, 1'b0, "wrap_rd");
        end

        // Flush wins over a concurrent write and clears sticky flags
        s_cycle(1'b0, 1'b1, '0, 1'b0, "udf2");
        for (int i = 0; i < 4; i++) s_cycle(1'b1, 1'b0, 16'h0400 + 16'(i), 1'b0, "to4");
        s_cycle(1'b1, 1'b0, 16'hDEAD, 1'b1, "clr_wr");
        s_cycle(1'b1, 1'b0, 16'h0077, 1'b0, "post_clr_wr");
        s_cycle(1'b0, 1'b1, '0, 1'b0, "post_clr_rd");

        for (int i = 0; i < 60; i++)
            s_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, "s_rand");

        // FWFT: write-to-dout latency, pops, capacity, back-to-back drain
        f_cycle(1'b1, 1'b0, 16'h1234, "fw_wr1");
        f_cycle(1'b0, 1'b0, '0, "fw_show");
        f_cycle(1'b1, 1'b0, 16'h5678, "fw_wr2");
        f_cycle(1'b0, 1'b1, '0, "fw_pop1");
        f_cycle(1'b0, 1'b1, '0, "fw_pop2");
        for (int i = 0; i < 9; i++) f_cycle(1'b1, 1'b0, 16'h0A00 + 16'(i), "fw_fill");
        for (int i = 0; i < 9; i++) f_cycle(1'b0, 1'b1, '0, "fw_drain");
        for (int i = 0; i < 60; i++)
            f_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), "f_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
